// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered 8N1 UART transmitter: FSM states and frame constants.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned UART_DIV_10M_115200 = 87;
    localparam int unsigned DATA_BITS           = 8;
    localparam logic        START_LEVEL         = 1'b0;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags and occupancy count.
module uart_tx_fifo_sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = (AW+1)'(2 ** AW);

    logic [DW-1:0] mem [2 ** AW];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // full is held high during reset so upstream sees no room until the cycle after release
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH);
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised LSB-first on tx.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLK_DIV   = UART_DIV_10M_115200,
    parameter int unsigned FIFO_AW   = 4,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_count
);

    localparam int unsigned STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int unsigned BAUD_W   = $clog2(STOP_LEN);
    localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLK_DIV - 1);
    localparam logic [BAUD_W-1:0] STOP_END = BAUD_W'(STOP_LEN - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    assign tx_ready  = ~fifo_full;
    assign fifo_push = tx_valid & tx_ready;

    uart_tx_fifo_sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // tx_d is the line level for the state being entered, so tx stays a plain register
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    bit_d    = '0;
                    state_d  = StStart;
                    tx_d     = START_LEVEL;
                end
            end
            StStart: begin
                if (baud_q == BIT_END) begin
                    baud_d  = '0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (baud_q == BIT_END) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (baud_q == STOP_END) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        bit_d    = '0;
                        state_d  = StStart;
                        tx_d     = START_LEVEL;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) | (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: frame-level reference model plus a UART receiver decode.
module tb_uart_tx_fifo;

    localparam int CDIV  = 4;
    localparam int FL    = 10 * CDIV;
    localparam int DEPTH = 16;
    localparam int CDIV2 = 87;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx, busy;
    logic [4:0] fifo_count;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2, tx2, busy2;
    logic [4:0] fifo_count2;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: queued bytes, current frame byte and position in the frame (-1 = idle)
    logic [7:0] q[$];
    logic [7:0] cur;
    int         pos;
    logic       m_ready;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_DIV(CDIV), .FIFO_AW(4), .STOP_BITS(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(.CLK_DIV(CDIV2), .FIFO_AW(4), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .tx         (tx2),
        .busy       (busy2),
        .fifo_count (fifo_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (pos < 0) return 1'b1;
        k = pos / CDIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic v, input logic r, input logic [7:0] d);
        logic push;
        if (r) begin
            q.delete();
            pos     = -1;
            m_ready = 1'b0;
            return;
        end
        push = v && m_ready;
        if (pos < 0) begin
            if (q.size() > 0) begin
                cur = q.pop_front();
                pos = 0;
            end
        end else begin
            pos++;
            if (pos == FL) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    pos = 0;
                end else begin
                    pos = -1;
                end
            end
        end
        if (push) q.push_back(d);
        m_ready = (q.size() < DEPTH);
    endtask

    task automatic tick();
        logic       v, r;
        logic [7:0] d;
        v = tx_valid;
        r = reset;
        d = tx_data;
        @(posedge clk);
        model_edge(v, r, d);
        #1;
        chk("tx", tx, exp_tx());
        chk("tx_ready", tx_ready, m_ready);
        chk("busy", busy, (pos >= 0) || (q.size() != 0));
        chk("fifo_count", fifo_count, q.size());
    endtask

    initial begin
        int         peak;
        int         nacc;
        logic       saw_full;
        logic       acc;
        logic [7:0] rx_byte;
        logic       samp[$];
        logic [7:0] seq3[3];

        reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
        tx_valid2 = 1'b0; tx_data2 = '0;
        pos = -1; m_ready = 1'b0; cur = '0;

        // reset held 3 cycles, then release
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // single byte 0xA5
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (45) tick();

        // three back-to-back bytes
        seq3[0] = 8'h00; seq3[1] = 8'hFF; seq3[2] = 8'h55;
        peak = 0;
        for (int i = 0; i < 3; i++) begin
            tx_data = seq3[i]; tx_valid = 1'b1;
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        tx_valid = 1'b0;
        repeat (130) begin
            tick();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        chk("peak_count", peak, 2);

        // fill past depth while the line is busy
        nacc = 0; saw_full = 1'b0;
        tx_valid = 1'b1; tx_data = 8'($urandom);
        for (int i = 0; i < 2000 && nacc < 18; i++) begin
            acc = m_ready;
            tick();
            if (!m_ready) saw_full = 1'b1;
            if (acc) begin
                nacc++;
                tx_data = 8'($urandom);
            end
        end
        tx_valid = 1'b0;
        chk("full_seen", saw_full, 1'b1);
        chk("accepted", nacc, 18);
        for (int i = 0; i < 1000 && (pos >= 0 || q.size() != 0); i++) tick();

        // reset in the middle of a frame with bytes queued
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        repeat (13) tick();
        reset = 1'b1;
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_count", fifo_count, 0);
        reset = 1'b0;
        repeat (60) tick();

        // random traffic
        repeat (400) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 2000 && (pos >= 0 || q.size() != 0); i++) tick();
        chk("drained", q.size(), 0);

        // CLK_DIV=87, two stop bits, byte 0x3C decoded by a receiver model
        tx_data2 = 8'h3C; tx_valid2 = 1'b1;
        tick();
        tx_valid2 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!busy2) break;
            samp.push_back(tx2);
        end
        chk("frame_len", samp.size(), 957);
        if (samp.size() >= 957) begin
            chk("start_bit", samp[CDIV2/2], 1'b0);
            for (int b = 0; b < 8; b++) rx_byte[b] = samp[(b + 1) * CDIV2 + CDIV2 / 2];
            chk("rx_byte", rx_byte, 8'h3C);
            chk("stop_bit1", samp[9 * CDIV2 + CDIV2 / 2], 1'b1);
            chk("stop_bit2", samp[10 * CDIV2 + CDIV2 / 2], 1'b1);
        end
        chk("idle_tx2", tx2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
